// File: rtl/sdram_arbiter_if.sv
// Request bundle between four bus masters, the arbiter and sdram_sys.
// Latency: none (wires only).
// Backpressure: port_req held until port_ack; req held until req_ack.
interface sdram_arbiter_if #(
  parameter int AN = 24,
  parameter int DN = 16
);
  logic [3:0]    port_req;
  logic [3:0]    port_wr;
  logic [AN-1:0] port_addr [4];
  logic [DN-1:0] port_data [4];
  logic [3:0]    port_ack;
  logic          req;
  logic          req_wr;
  logic [AN-1:0] req_addr;
  logic [DN-1:0] req_data;
  logic [1:0]    req_id;
  logic          req_ack;

  // Arbiter view: drives the downstream request and the per-port acks
  modport master (
    input  port_req, port_wr, port_addr, port_data, req_ack,
    output port_ack, req, req_wr, req_addr, req_data, req_id
  );

  // Environment view: bus masters plus sdram_sys
  modport slave (
    output port_req, port_wr, port_addr, port_data, req_ack,
    input  port_ack, req, req_wr, req_addr, req_data, req_id
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Four-port round-robin arbiter feeding single-word requests to sdram_sys.
// Latency: req rises on the edge that samples port_req; port_ack on the req_ack edge.
// Backpressure: one outstanding request; outputs frozen until req_ack, then one idle cycle.
module sdram_arbiter #(
  parameter int AN = 24,
  parameter int DN = 16
) (
  input logic             clkSYS,
  input logic             n_reset,
  sdram_arbiter_if.master bus
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        state, state_nxt;
  logic [1:0]    grant, grant_nxt;
  logic [1:0]    last, last_nxt;
  logic          req_q, req_nxt;
  logic          wr_q, wr_nxt;
  logic [AN-1:0] addr_q, addr_nxt;
  logic [DN-1:0] data_q, data_nxt;
  logic [1:0]    id_q, id_nxt;
  logic [3:0]    ack_q, ack_nxt;

  logic [3:0]    eligible;
  logic          found;
  logic [1:0]    winner;
  logic [1:0]    cand;

  // Round-robin search starting just after the last served port; a port whose
  // ack is showing this cycle is masked because its master cannot have dropped yet
  always_comb begin
    eligible = bus.port_req & ~ack_q;
    found    = 1'b0;
    winner   = last;
    cand     = last;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next-state and registered-output values for the Idle/Busy handshake
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    req_nxt   = req_q;
    wr_nxt    = wr_q;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    id_nxt    = id_q;
    ack_nxt   = 4'b0000;
    case (state)
      S_IDLE: begin
        if (found) begin
          wr_nxt    = bus.port_wr[winner];
          addr_nxt  = bus.port_addr[winner];
          data_nxt  = bus.port_data[winner];
          id_nxt    = winner;
          grant_nxt = winner;
          req_nxt   = 1'b1;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        // Payload outputs keep their values after the handshake completes
        if (bus.req_ack) begin
          req_nxt   = 1'b0;
          ack_nxt   = 4'b0001 << grant;
          last_nxt  = grant;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; last resets to 3 so port 0 wins first
  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      state  <= S_IDLE;
      grant  <= 2'd0;
      last   <= 2'd3;
      req_q  <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      id_q   <= 2'd0;
      ack_q  <= 4'b0000;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      last   <= last_nxt;
      req_q  <= req_nxt;
      wr_q   <= wr_nxt;
      addr_q <= addr_nxt;
      data_q <= data_nxt;
      id_q   <= id_nxt;
      ack_q  <= ack_nxt;
    end
  end

  assign bus.req      = req_q;
  assign bus.req_wr   = wr_q;
  assign bus.req_addr = addr_q;
  assign bus.req_data = data_q;
  assign bus.req_id   = id_q;
  assign bus.port_ack = ack_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized and directed bench for sdram_arbiter against a transaction-level model.
// Latency: checks every cycle, 1 time unit after the rising edge.
// Backpressure: bench plays the four masters and a sdram_sys with variable service time.
module tb_sdram_arbiter;
  localparam int AN = 24;
  localparam int DN = 16;

  logic clkSYS = 1'b0;
  logic n_reset = 1'b1;
  always #5 clkSYS = ~clkSYS;

  sdram_arbiter_if #(.AN(AN), .DN(DN)) bus ();
  sdram_arbiter #(.AN(AN), .DN(DN)) dut (.clkSYS(clkSYS), .n_reset(n_reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one outstanding transaction, remembered payload, last server
  bit            m_busy;
  int            m_port;
  int            m_last;
  int            m_ack;   // port acknowledged at the most recent edge, -1 if none
  bit            m_wr;
  logic [AN-1:0] m_addr;
  logic [DN-1:0] m_data;

  // Stimulus knobs
  int start_pct;
  int svc_mode;   // -1: random service delay, else fixed
  int rel_mode;   // -1: random release delay, else 0/1 cycles after ack
  bit ds_en;
  bit junk;
  int svc;
  bit hold [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_port = 0;
    m_last = 3;
    m_ack  = -1;
    m_wr   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // Transaction view of one clock edge: finish the current request on req_ack,
  // otherwise pick the next requester in rotation after the last one served
  task automatic model_step();
    int prev_ack;
    prev_ack = m_ack;
    m_ack = -1;
    if (m_busy) begin
      if (bus.req_ack) begin
        m_busy = 1'b0;
        m_ack  = m_port;
        m_last = m_port;
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        int p;
        p = (m_last + k) % 4;
        if (bus.port_req[p] && p != prev_ack) begin
          m_busy = 1'b1;
          m_port = p;
          m_wr   = bus.port_wr[p];
          m_addr = bus.port_addr[p];
          m_data = bus.port_data[p];
          break;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("req",      64'(bus.req),      64'(m_busy));
    check("req_id",   64'(bus.req_id),   64'(m_port));
    check("req_wr",   64'(bus.req_wr),   64'(m_wr));
    check("req_addr", 64'(bus.req_addr), 64'(m_addr));
    check("req_data", 64'(bus.req_data), 64'(m_data));
    check("port_ack", 64'(bus.port_ack), (m_ack < 0) ? 64'd0 : (64'd1 << m_ack));
  endtask

  task automatic cycle();
    @(posedge clkSYS);
    model_step();
    #1;
    check_outputs();
  endtask

  // Masters release/start requests; sdram_sys answers after a service delay
  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (bus.port_req[i]) begin
        if (hold[i]) begin
          bus.port_req[i] = 1'b0;
          hold[i] = 1'b0;
        end else if (bus.port_ack[i]) begin
          if (((rel_mode < 0) ? int'($urandom_range(0, 1)) : rel_mode) == 0)
            bus.port_req[i] = 1'b0;
          else
            hold[i] = 1'b1;
        end
      end else if (int'($urandom_range(0, 99)) < start_pct) begin
        bus.port_req[i]  = 1'b1;
        bus.port_wr[i]   = 1'($urandom_range(0, 1));
        bus.port_addr[i] = AN'($urandom);
        bus.port_data[i] = DN'($urandom);
      end
    end
    if (bus.req_ack) begin
      bus.req_ack = 1'b0;
    end else if (ds_en && bus.req) begin
      if (svc < 0) svc = (svc_mode < 0) ? int'($urandom_range(0, 4)) : svc_mode;
      if (svc == 0) begin
        bus.req_ack = 1'b1;
        svc = -1;
      end else begin
        svc--;
      end
    end else if (junk && !bus.req && $urandom_range(0, 3) == 0) begin
      bus.req_ack = 1'b1;
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      cycle();
      drive();
    end
  endtask

  task automatic post(input int p, input bit wr, input logic [AN-1:0] a, input logic [DN-1:0] d);
    bus.port_req[p]  = 1'b1;
    bus.port_wr[p]   = wr;
    bus.port_addr[p] = a;
    bus.port_data[p] = d;
  endtask

  task automatic quiet(input int n);
    start_pct = 0; svc_mode = -1; rel_mode = 0; ds_en = 1'b1; junk = 1'b0;
    run(n);
  endtask

  initial begin
    bus.port_req = '0;
    bus.port_wr  = '0;
    for (int i = 0; i < 4; i++) begin
      bus.port_addr[i] = '0;
      bus.port_data[i] = '0;
      hold[i] = 1'b0;
    end
    bus.req_ack = 1'b0;
    start_pct = 0; svc_mode = -1; rel_mode = 0; ds_en = 1'b0; junk = 1'b0; svc = -1;
    model_reset();

    // Reset values
    #1 n_reset = 1'b0;
    #1 check_outputs();

    // Single read on port 2, held Busy, then reset while req is high
    #20;
    n_reset = 1'b1;
    post(2, 1'b0, 24'h123456, 16'h0000);
    cycle();
    run(3);
    bus.port_req = '0;
    n_reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #2 n_reset = 1'b1;

    // Ports 1 and 3 together straight after reset: 1 goes first
    post(1, 1'b0, 24'h0A0001, 16'h1111);
    post(3, 1'b1, 24'h0A0003, 16'h3333);
    quiet(20);

    // Single write with a 5-cycle downstream service time
    post(1, 1'b1, 24'h000010, 16'hBEEF);
    start_pct = 0; svc_mode = 4; rel_mode = 0; ds_en = 1'b1; junk = 1'b0;
    run(12);

    // Port 3 alone, master drops req one cycle after its ack
    post(3, 1'b0, 24'h0C0C0C, 16'h0303);
    rel_mode = 1; svc_mode = 2;
    run(12);

    // Back-to-back on ports 0 and 1, plus stray req_ack while idle
    post(0, 1'b1, 24'h000100, 16'hA0A0);
    post(1, 1'b0, 24'h000200, 16'hB1B1);
    svc_mode = 1; rel_mode = 1; junk = 1'b1;
    run(16);

    // All four ports requesting continuously
    quiet(40);
    start_pct = 100; svc_mode = 0; rel_mode = 0; junk = 1'b0;
    run(40);

    // Random traffic
    quiet(40);
    start_pct = 30; svc_mode = -1; rel_mode = -1; junk = 1'b1;
    run(1500);

    quiet(40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
